// File: rtl/mandel_iter_ctrl.sv
// rtl/mandel_iter_ctrl.sv - escape-time iteration sequencer for one Mandelbrot point
// Accepts c, loads z, steps the datapath to escape or limit, then returns the count.
module mandel_iter_ctrl #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
  output logic [DATA_W-1:0] dp_c_re,
  output logic [DATA_W-1:0] dp_c_im,
  output logic              dp_ld,
  output logic              dp_en,
  input  logic              dp_diverged,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_escaped
);

  if (MAX_ITER < 1 || MAX_ITER >= (1 << CNT_W)) begin : g_bad_max_iter
    $error("mandel_iter_ctrl: MAX_ITER must be >= 1 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_iter_cnt;
  logic [DATA_W-1:0]   r_c_re;
  logic [DATA_W-1:0]   r_c_im;
  logic [CNT_W-1:0]    r_res_count;
  logic                r_res_escaped;
  logic                w_accept;
  logic                w_finish;
  logic                w_escape;

  // Divergence is tested before the limit so a coincident flag still reports escaped.
  always_comb begin
    w_next    = r_state;
    pt_ready  = 1'b0;
    dp_ld     = 1'b0;
    dp_en     = 1'b0;
    res_valid = 1'b0;
    w_accept  = 1'b0;
    w_finish  = 1'b0;
    w_escape  = 1'b0;
    case (r_state)
      S_IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        dp_ld  = 1'b1;
        w_next = S_ITER;
      end
      S_ITER: begin
        if (dp_diverged) begin
          w_finish = 1'b1;
          w_escape = 1'b1;
          w_next   = S_DONE;
        end else if (r_iter_cnt == MAX_CNT) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end else begin
          dp_en = 1'b1;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_iter_cnt    <= '0;
      r_c_re        <= '0;
      r_c_im        <= '0;
      r_res_count   <= '0;
      r_res_escaped <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_c_re     <= c_re;
        r_c_im     <= c_im;
        r_iter_cnt <= '0;
      end else if (dp_ld) begin
        r_iter_cnt <= '0;
      end else if (dp_en) begin
        r_iter_cnt <= r_iter_cnt + CNT_W'(1);
      end
      // On the limit path r_iter_cnt already equals MAX_ITER, so one capture serves both exits.
      if (w_finish) begin
        r_res_count   <= r_iter_cnt;
        r_res_escaped <= w_escape;
      end
    end
  end

  assign dp_c_re     = r_c_re;
  assign dp_c_im     = r_c_im;
  assign res_count   = r_res_count;
  assign res_escaped = r_res_escaped;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// tb/tb_mandel_iter_ctrl.sv - self-checking bench for mandel_iter_ctrl
// A datapath stub raises dp_diverged after stub_n steps since the last load.
module tb_mandel_iter_ctrl;

  localparam int DATA_W   = 32;
  localparam int CNT_W    = 8;
  localparam int MAX_ITER = 255;

  logic              clk;
  logic              rst;
  logic              pt_valid;
  logic              pt_ready;
  logic [DATA_W-1:0] c_re;
  logic [DATA_W-1:0] c_im;
  logic [DATA_W-1:0] dp_c_re;
  logic [DATA_W-1:0] dp_c_im;
  logic              dp_ld;
  logic              dp_en;
  logic              dp_diverged;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_escaped;

  int checks = 0;
  int errors = 0;
  int stub_n = 1000;
  int stub_cnt = 0;

  mandel_iter_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .c_re(c_re), .c_im(c_im),
    .dp_c_re(dp_c_re), .dp_c_im(dp_c_im),
    .dp_ld(dp_ld), .dp_en(dp_en), .dp_diverged(dp_diverged),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_escaped(res_escaped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_ld) stub_cnt <= 0;
    else if (dp_en) stub_cnt <= stub_cnt + 1;
  end
  assign dp_diverged = (stub_cnt >= stub_n);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A point needing n steps escapes at n if n fits under the limit, otherwise reports the limit.
  task automatic run_job(input logic [31:0] cre, input logic [31:0] cim, input int n,
                         input bit keep_valid, input bit bp);
    int exp_cnt;
    bit exp_esc;
    int e;
    int en_pulses;
    int k;
    exp_cnt = (n <= MAX_ITER) ? n : MAX_ITER;
    exp_esc = (n <= MAX_ITER);
    stub_n = n;
    c_re = cre;
    c_im = cim;
    pt_valid = 1'b1;
    res_ready = !bp;
    k = 0;
    while (!pt_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", pt_ready, 1);
    @(negedge clk);
    if (!keep_valid) begin
      pt_valid = 1'b0;
      c_re = $urandom;
      c_im = $urandom;
    end
    chk("ld_after_accept", dp_ld, 1);
    e = 0;
    en_pulses = 0;
    while (!res_valid && e < 2000) begin
      chk("ld_en_overlap", dp_ld & dp_en, 0);
      chk("busy_pt_ready", pt_ready, 0);
      chk("dp_c_re_hold", dp_c_re, cre);
      chk("dp_c_im_hold", dp_c_im, cim);
      if (dp_en) en_pulses++;
      @(negedge clk);
      e++;
    end
    chk("res_latency", e, exp_cnt + 2);
    chk("dp_en_pulses", en_pulses, exp_cnt);
    chk("res_count", res_count, exp_cnt);
    chk("res_escaped", res_escaped, exp_esc);
    if (bp) begin
      c_re = $urandom;
      c_im = $urandom;
      pt_valid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_res_count", res_count, exp_cnt);
        chk("bp_res_escaped", res_escaped, exp_esc);
        chk("bp_pt_ready", pt_ready, 0);
        chk("bp_dp_c_re", dp_c_re, cre);
        chk("bp_dp_c_im", dp_c_im, cim);
      end
      res_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_hs_res_valid", res_valid, 0);
    chk("post_hs_pt_ready", pt_ready, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    pt_valid = 1'b0;
    res_ready = 1'b0;
    c_re = '0;
    c_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_pt_ready", pt_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dp_ld", dp_ld, 0);
    chk("rst_dp_en", dp_en, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_escaped", res_escaped, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset while iterating.
    stub_n = 1000;
    c_re = 32'h1234_5678;
    c_im = 32'h9abc_def0;
    pt_valid = 1'b1;
    @(negedge clk);
    pt_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_iter_dp_en", dp_en, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_pt_ready", pt_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_dp_ld", dp_ld, 0);
    chk("midrst_dp_en", dp_en, 0);
    chk("midrst_dp_c_re", dp_c_re, 0);
    chk("midrst_dp_c_im", dp_c_im, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_pt_ready", pt_ready, 1);

    run_job(32'h0040_0000, 32'hFFC0_0000, 5, 1'b0, 1'b0);
    run_job(32'h0, 32'h0, 1000, 1'b0, 1'b0);
    run_job($urandom, $urandom, 255, 1'b0, 1'b0);
    run_job($urandom, $urandom, 0, 1'b0, 1'b0);
    run_job($urandom, $urandom, 3, 1'b0, 1'b1);
    run_job($urandom, $urandom, 4, 1'b0, 1'b0);

    for (int j = 1; j <= 3; j++) begin
      run_job($urandom, $urandom, j, 1'b1, 1'b0);
    end
    pt_valid = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 8; j++) begin
      k = $urandom_range(0, 300);
      run_job($urandom, $urandom, k, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
